// File: rtl/keyword_confirm_if.sv
// Keyword confirmation handshake bundle: raw classifier IDs in, confirmed IDs out.
// Carries kw_count only when KW_CONFIRM_STATS_EN is defined.
interface keyword_confirm_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] kw_in;
  logic            kw_in_valid;
  logic [ID_W-1:0] kw_out;
  logic            kw_out_valid;
  logic            kw_out_ready;
  logic            busy;
  logic            overflow;
`ifdef KW_CONFIRM_STATS_EN
  logic [15:0]     kw_count;

  modport master (
    output kw_in, kw_in_valid, kw_out_ready,
    input  kw_out, kw_out_valid, busy, overflow, kw_count
  );
  modport slave (
    input  kw_in, kw_in_valid, kw_out_ready,
    output kw_out, kw_out_valid, busy, overflow, kw_count
  );
`else
  modport master (
    output kw_in, kw_in_valid, kw_out_ready,
    input  kw_out, kw_out_valid, busy, overflow
  );
  modport slave (
    input  kw_in, kw_in_valid, kw_out_ready,
    output kw_out, kw_out_valid, busy, overflow
  );
`endif
endinterface

// File: rtl/keyword_confirm.sv
// Keyword confirmation: N identical non-zero IDs in a row, one-shot output, holdoff.
// KW_CONFIRM_STATS_EN adds a saturating handshake counter (kw_count).
module keyword_confirm #(
  parameter int CONFIRM_COUNT  = 4,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int ID_W           = 4
) (
  input logic              clk,
  input logic              rst,
  keyword_confirm_if.slave bus
);

  localparam int CW = $clog2(CONFIRM_COUNT + 1);
  localparam int HW = (HOLDOFF_CYCLES > 0) ?
                      $clog2(HOLDOFF_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAND = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [ID_W-1:0] cand_q, cand_d;
  logic [ID_W-1:0] out_q, out_d;
  logic            vld_q, vld_d;
  logic            ovf_q, ovf_d;
  logic            emit;
  logic            hs;

  assign hs = vld_q & bus.kw_out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    cand_d  = cand_q;
    emit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.kw_in_valid && bus.kw_in != '0) begin
          cand_d  = bus.kw_in;
          cnt_d   = CW'(1);
          state_d = S_CAND;
        end
      end
      S_CAND: begin
        if (bus.kw_in_valid) begin
          unique case (1'b1)
            bus.kw_in == cand_q: begin
              if (cnt_q + CW'(1) == CW'(CONFIRM_COUNT)) begin
                emit   = 1'b1;
                cnt_d  = '0;
                hold_d = HW'(HOLDOFF_CYCLES);
                state_d = (HOLDOFF_CYCLES > 0) ?
                          S_HOLD : S_IDLE;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            bus.kw_in == '0: begin
              cnt_d   = '0;
              state_d = S_IDLE;
            end
            default: begin
              cand_d = bus.kw_in;
              cnt_d  = CW'(1);
            end
          endcase
        end
      end
      S_HOLD: begin
        // counter reads HOLDOFF_CYCLES..1 while here, input ignored
        hold_d = hold_q - HW'(1);
        if (hold_q == HW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    ovf_d = ovf_q;
    if (emit) begin
      if (!vld_q || bus.kw_out_ready) begin
        out_d = cand_q;
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (hs) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      cand_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      cand_q  <= cand_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.kw_out       = out_q;
  assign bus.kw_out_valid = vld_q;
  assign bus.overflow     = ovf_q;
  assign bus.busy         = (state_q != S_IDLE);

`ifdef KW_CONFIRM_STATS_EN
  logic [15:0] kwc_q, kwc_d;

  always_comb begin
    kwc_d = kwc_q;
    if (hs && kwc_q != 16'hFFFF) kwc_d = kwc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) kwc_q <= '0;
    else     kwc_q <= kwc_d;
  end

  assign bus.kw_count = kwc_q;
`endif

endmodule
